// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush and a
// multi-cycle divide stall. Optional stall counter enabled by PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_div,
  input  logic        branch_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic {RUN = 1'b0, DIV_WAIT = 1'b1} state_t;

  // The trigger cycle in RUN is the first stalled cycle, so the counter
  // covers the remaining DIV_CYCLES-1 stalls before the release cycle.
  localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  logic [4:0] src_idx [2];
  logic [1:0] src_used;
  logic [1:0] src_match;
  logic       load_use;
  logic       div_start;

  assign src_idx[0]  = id_rs1;
  assign src_idx[1]  = id_rs2;
  assign src_used[0] = id_rs1_used;
  assign src_used[1] = id_rs2_used;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = src_used[gi] && (src_idx[gi] == ex_rd);
    end
  endgenerate

  assign load_use  = ex_valid && ex_mem_read && (ex_rd != 5'd0) && (|src_match);
  assign div_start = !branch_taken && ex_valid && ex_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (div_start) begin
          state_next = DIV_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      DIV_WAIT: begin
        // Release cycle always returns to RUN, so a lingering ex_div cannot retrigger.
        if (cnt_reg != 8'd0) cnt_next = cnt_reg - 8'd1;
        else                 state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    div_busy    = 1'b0;
    div_done    = 1'b0;
    if (!rst) begin
      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_valid && ex_div) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        DIV_WAIT: begin
          div_busy = 1'b1;
          if (cnt_reg != 8'd0) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
          end else begin
            div_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk) begin
    if (rst)                                     perf_reg <= 32'd0;
    else if (pc_stall && (perf_reg != 32'hFFFF_FFFF)) perf_reg <= perf_reg + 32'd1;
  end

  assign perf_stall_cnt = perf_reg;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the stall rules.
module tb_pipeline_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_valid, ex_mem_read, ex_div, branch_taken;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush;
  logic        div_busy, div_done;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: whether a divide is in progress and how many stall cycles it has used.
  bit          m_in_div;
  int          m_stalled;
  logic [31:0] m_perf;

  pipeline_ctrl #(.DIV_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_div(ex_div), .branch_taken(branch_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .div_busy(div_busy), .div_done(div_done), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic v, input logic [4:0] rd,
                       input logic ld, input logic dv, input logic br,
                       input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2);
    @(negedge clk);
    rst = r; ex_valid = v; ex_rd = rd; ex_mem_read = ld; ex_div = dv;
    branch_taken = br; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
  endtask

  // Compare this cycle's outputs against the model, then advance the model past the edge.
  task automatic check_cycle(input string tag);
    logic [7:0] exp_v, obs_v;
    logic       hazard;
    bit         stalling;
    #1;
    hazard = ex_valid && ex_mem_read && (ex_rd != 0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    // order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_flush div_busy div_done
    exp_v = 8'b0;
    if (rst)                        exp_v = 8'b0;
    else if (m_in_div)              exp_v = (m_stalled < D) ? 8'b1101_0110 : 8'b0000_0011;
    else if (branch_taken)          exp_v = 8'b0010_1000;
    else if (ex_valid && ex_div)    exp_v = 8'b1101_0100;
    else if (hazard)                exp_v = 8'b1100_1000;
    obs_v = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush,
             div_busy, div_done};

    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s outputs: got %b expected %b", tag, obs_v, exp_v);
    end
    checks++;
    assert (perf_stall_cnt === m_perf) else begin
      errors++;
      $error("FAIL %s perf_stall_cnt: got %0d expected %0d", tag, perf_stall_cnt, m_perf);
    end
    checks++;
    assert (!(ifid_stall && ifid_flush)) else begin
      errors++;
      $error("FAIL %s ifid_excl: got stall=%b flush=%b expected not both", tag, ifid_stall, ifid_flush);
    end
    $display("%s: rst=%b in=%b%b%b%b hz=%b out=%b perf=%0d", tag, rst, ex_valid, ex_mem_read,
             ex_div, branch_taken, hazard, obs_v, perf_stall_cnt);

    stalling = exp_v[7];
    if (rst) begin
      m_in_div = 0; m_stalled = 0; m_perf = 32'd0;
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      if (stalling && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
`endif
      if (m_in_div) begin
        if (m_stalled < D) m_stalled++;
        else m_in_div = 0;
      end else if (!branch_taken && ex_valid && ex_div) begin
        m_in_div = 1; m_stalled = 1;
      end
    end
  endtask

  initial begin
    m_in_div = 0; m_stalled = 0; m_perf = 32'd0;
    rst = 1; ex_valid = 0; ex_rd = 0; ex_mem_read = 0; ex_div = 0; branch_taken = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;

    drive(1, 1, 5, 1, 1, 1, 5, 1, 5, 1); check_cycle("reset_busy_inputs");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_cycle("idle");

    // Load-use hazard on rs1, then the same with x0 as destination.
    drive(0, 1, 5, 1, 0, 0, 5, 1, 0, 0); check_cycle("load_use_rs1");
    drive(0, 1, 0, 1, 0, 0, 0, 1, 0, 0); check_cycle("load_use_x0");
    drive(0, 1, 7, 1, 0, 0, 1, 0, 7, 1); check_cycle("load_use_rs2");
    drive(0, 1, 7, 1, 0, 0, 7, 0, 1, 0); check_cycle("unused_src");
    // Branch dominates a coincident hazard.
    drive(0, 1, 5, 1, 0, 1, 5, 1, 0, 0); check_cycle("branch_over_hazard");

    // Divide held high through the release cycle, plus ignored hazard/branch.
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0, 0); check_cycle("div_trigger");
    drive(0, 1, 3, 1, 1, 1, 3, 1, 0, 0); check_cycle("div_wait_1");
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0, 0); check_cycle("div_wait_2");
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0, 0); check_cycle("div_wait_3");
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0, 0); check_cycle("div_release");
    // Hazard pending right after the release is handled normally.
    drive(0, 1, 9, 1, 0, 0, 9, 1, 0, 0); check_cycle("post_div_hazard");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_cycle("post_div_idle");

    // Reset during the second DIV_WAIT cycle aborts the divide.
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0, 0); check_cycle("abort_trigger");
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0, 0); check_cycle("abort_wait_1");
    drive(1, 1, 3, 0, 1, 0, 0, 0, 0, 0); check_cycle("abort_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_cycle("abort_after");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_cycle("abort_after2");

    // One load-use stall plus one divide gives D+1 counted stall cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_cycle("perf_reset");
    drive(0, 1, 4, 1, 0, 0, 4, 1, 0, 0); check_cycle("perf_load_use");
    drive(0, 1, 2, 0, 1, 0, 0, 0, 0, 0); check_cycle("perf_div");
    for (int i = 0; i < D; i++) begin
      drive(0, 1, 2, 0, 1, 0, 0, 0, 0, 0); check_cycle("perf_div_wait");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_cycle("perf_final");
    checks++;
`ifdef PIPE_CTRL_PERF_EN
    assert (perf_stall_cnt === 32'd5) else begin
      errors++;
      $error("FAIL perf_total: got %0d expected 5", perf_stall_cnt);
    end
`else
    assert (perf_stall_cnt === 32'd0) else begin
      errors++;
      $error("FAIL perf_total: got %0d expected 0", perf_stall_cnt);
    end
`endif

    // Random traffic with a small register range so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 49)) == 5'd0,
            $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      check_cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
